// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light controller and its monitor:
// phase codes, FSM state codes and active-high 7-segment digit patterns (bit0=a .. bit6=g).
package traffic_light_pkg;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_G    = 2'd1,
        PH_Y    = 2'd2,
        PH_R    = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_RED    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Legal order is G -> Y -> R -> G.
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        n = PH_NONE;
        case (p)
            PH_G:    n = PH_Y;
            PH_Y:    n = PH_R;
            PH_R:    n = PH_G;
            default: n = PH_NONE;
        endcase
        return n;
    endfunction

    function automatic state_t phase_state(input phase_t p);
        state_t s;
        s = S_SYNC;
        case (p)
            PH_G:    s = S_GREEN;
            PH_Y:    s = S_YELLOW;
            PH_R:    s = S_RED;
            default: s = S_SYNC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purpose: 7-segment pattern to BCD digit, valid low for any non-digit pattern.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module seven_seg_decoder
    import traffic_light_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Purpose: checks lamp order, countdown and per-second timing of a traffic light output; optional TL_MON_TIMEOUT_EN adds err_stall.
// Latency: inputs registered once, outputs registered one clk later (2 clk input to output).
// Backpressure: none; en low freezes every register and suppresses all flag updates.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int pSECOND_CNT_VAL    = 99,
    parameter int pTIME_GREEN_LIGHT  = 15,
    parameter int pTIME_YELLOW_LIGHT = 3,
    parameter int pTIME_RED_LIGHT    = 18,
    parameter int pCYCLE_CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        green_light,
    input  logic                        yellow_light,
    input  logic                        red_light,
    input  logic [6:0]                  seg_a,
    input  logic [6:0]                  seg_b,
    output logic [1:0]                  phase,
    output logic [6:0]                  disp_val,
    output logic [pCYCLE_CNT_WIDTH-1:0] cycle_cnt,
    output logic                        err_onehot,
    output logic                        err_seg,
    output logic                        err_seq,
    output logic                        err_count,
    output logic                        err_time,
    output logic                        err_any
`ifdef TL_MON_TIMEOUT_EN
    ,
    output logic                        err_stall
`endif
);

    localparam int SEC_CLKS = pSECOND_CNT_VAL + 1;
    localparam int CNT_MAX  = 256 * SEC_CLKS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // Input register stage
    logic [2:0] lamp_q;
    logic [6:0] seg_a_q;
    logic [6:0] seg_b_q;
    logic       en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q  <= 3'b000;
            seg_a_q <= 7'h00;
            seg_b_q <= 7'h00;
            en_q    <= 1'b0;
        end else begin
            en_q <= en;
            if (en) begin
                lamp_q  <= {red_light, yellow_light, green_light};
                seg_a_q <= seg_a;
                seg_b_q <= seg_b;
            end
        end
    end

    logic [3:0] dig_a;
    logic [3:0] dig_b;
    logic       vld_a;
    logic       vld_b;

    seven_seg_decoder u_dec_tens  (.seg(seg_a_q), .digit(dig_a), .valid(vld_a));
    seven_seg_decoder u_dec_units (.seg(seg_b_q), .digit(dig_b), .valid(vld_b));

    logic [6:0] new_val;
    phase_t     lamp_ph;

    assign new_val = ({3'b000, dig_a} * 7'd10) + {3'b000, dig_b};

    always_comb begin
        lamp_ph = PH_NONE;
        case (lamp_q)
            3'b001:  lamp_ph = PH_G;
            3'b010:  lamp_ph = PH_Y;
            3'b100:  lamp_ph = PH_R;
            default: lamp_ph = PH_NONE;
        endcase
    end

    function automatic logic [6:0] entry_time(input phase_t p);
        logic [6:0] t;
        t = 7'd0;
        case (p)
            PH_G:    t = 7'(pTIME_GREEN_LIGHT);
            PH_Y:    t = 7'(pTIME_YELLOW_LIGHT);
            PH_R:    t = 7'(pTIME_RED_LIGHT);
            default: t = 7'd0;
        endcase
        return t;
    endfunction

    // Check stage state
    state_t                      state_q, state_d;
    phase_t                      phase_q, phase_d;
    logic [6:0]                  disp_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [pCYCLE_CNT_WIDTH-1:0] cyc_d;
    logic                        first_q, first_d;
    logic                        seq_bad_q, seq_bad_d;
    logic                        onehot_d, seg_d, seq_d, count_d, time_d, stall_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        disp_d    = disp_val;
        cnt_d     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        cyc_d     = cycle_cnt;
        first_d   = first_q;
        seq_bad_d = seq_bad_q;
        onehot_d  = err_onehot;
        seg_d     = err_seg;
        seq_d     = err_seq;
        count_d   = err_count;
        time_d    = err_time;
        stall_d   = 1'b0;

        if (!en) begin
            cnt_d = cnt_q;
        end else if (!en_q) begin
            // Data sampled before the freeze is stale: resynchronise.
            cnt_d   = '0;
            state_d = S_SYNC;
        end else if (lamp_ph == PH_NONE) begin
            onehot_d = 1'b1;
            phase_d  = PH_NONE;
            state_d  = S_SYNC;
        end else if (!(vld_a && vld_b)) begin
            seg_d = 1'b1;
        end else if (lamp_ph != phase_q) begin
            cnt_d   = '0;
            phase_d = lamp_ph;
            state_d = phase_state(lamp_ph);
            disp_d  = new_val;
            first_d = (state_q == S_SYNC);
            if (state_q == S_SYNC) begin
                seq_bad_d = 1'b0;
            end else begin
                if (disp_val != 7'd1)
                    count_d = 1'b1;
                if (new_val != entry_time(lamp_ph))
                    count_d = 1'b1;
                if (lamp_ph != next_phase(phase_q)) begin
                    seq_d     = 1'b1;
                    seq_bad_d = 1'b1;
                end
                // Only a cycle with no order violation since the last R->G counts.
                if (state_q == S_RED && lamp_ph == PH_G) begin
                    if (!seq_bad_q)
                        cyc_d = cycle_cnt + pCYCLE_CNT_WIDTH'(1);
                    seq_bad_d = 1'b0;
                end
            end
        end else if (new_val != disp_val) begin
            cnt_d   = '0;
            disp_d  = new_val;
            first_d = 1'b0;
            if (state_q != S_SYNC) begin
                if (new_val != disp_val - 7'd1)
                    count_d = 1'b1;
                if (!first_q && cnt_q != CNT_W'(pSECOND_CNT_VAL))
                    time_d = 1'b1;
            end
        end

`ifdef TL_MON_TIMEOUT_EN
        stall_d = err_stall | (en && en_q && (cnt_d >= CNT_W'(2 * SEC_CLKS)));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SYNC;
            phase_q    <= PH_NONE;
            disp_val   <= 7'd0;
            cnt_q      <= '0;
            cycle_cnt  <= '0;
            first_q    <= 1'b0;
            seq_bad_q  <= 1'b0;
            err_onehot <= 1'b0;
            err_seg    <= 1'b0;
            err_seq    <= 1'b0;
            err_count  <= 1'b0;
            err_time   <= 1'b0;
            err_any    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            disp_val   <= disp_d;
            cnt_q      <= cnt_d;
            cycle_cnt  <= cyc_d;
            first_q    <= first_d;
            seq_bad_q  <= seq_bad_d;
            err_onehot <= onehot_d;
            err_seg    <= seg_d;
            err_seq    <= seq_d;
            err_count  <= count_d;
            err_time   <= time_d;
            err_any    <= onehot_d | seg_d | seq_d | count_d | time_d | stall_d;
        end
    end

`ifdef TL_MON_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_stall <= 1'b0;
        else
            err_stall <= stall_d;
    end
`endif

    assign phase = phase_q;

endmodule
